// File: rtl/alu_issue.sv
// ALU issue stage: register file, operand select, scoreboard hazard stall, one-deep output register.
// Optional macro ALU_ISSUE_FWD_EN forwards same-cycle writeback data into a scoreboarded source.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [7:0]  wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_mode,
    output logic [7:0]  out_op1,
    output logic [7:0]  out_op2,
    output logic [2:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

    state_t      state, state_next;
    logic [7:0]  rf [8];
    logic [7:0]  scoreboard;

    logic [3:0]  op;
    logic [2:0]  f_rd, f_rs, f_rt;
    logic [7:0]  imm;

    logic [7:0]  src_mask, pend_mask, wb_mask, set_mask, fwd_mask;
    logic [7:0]  rd_val, rs_val, rt_val;
    logic        hazard, accept, xfer;

    logic [3:0]  d_mode;
    logic [7:0]  d_op1, d_op2;
    logic        d_we, d_illegal;

    assign op   = in_instr[15:12];
    assign f_rd = in_instr[11:9];
    assign f_rs = in_instr[8:6];
    assign f_rt = in_instr[5:3];
    assign imm  = in_instr[7:0];

    // The output register is occupied exactly when the FSM sits in ISSUE.
    assign out_valid = (state == ISSUE);

    assign pend_mask = (out_valid && out_we) ? (8'b1 << out_rd) : '0;
    assign wb_mask   = wb_en ? (8'b1 << wb_addr) : '0;
    assign xfer      = out_valid && out_ready;
    assign set_mask  = (xfer && out_we) ? (8'b1 << out_rd) : '0;

`ifdef ALU_ISSUE_FWD_EN
    assign fwd_mask = scoreboard & wb_mask & ~pend_mask;
`else
    assign fwd_mask = '0;
`endif

    assign rd_val = fwd_mask[f_rd] ? wb_data : rf[f_rd];
    assign rs_val = fwd_mask[f_rs] ? wb_data : rf[f_rs];
    assign rt_val = fwd_mask[f_rt] ? wb_data : rf[f_rt];

    always_comb begin
        d_mode    = '0;
        d_op1     = '0;
        d_op2     = '0;
        d_we      = 1'b0;
        d_illegal = 1'b0;
        src_mask  = '0;
        case (op)
            4'h0: d_mode = op;
            4'h1, 4'h5, 4'h6: begin
                d_mode   = op;
                d_op1    = rs_val;
                d_op2    = rt_val;
                d_we     = 1'b1;
                src_mask = (8'b1 << f_rs) | (8'b1 << f_rt);
            end
            4'h2, 4'h4: begin
                d_mode = op;
                d_op1  = imm;
                d_we   = 1'b1;
            end
            4'h3: begin
                d_mode   = op;
                d_op1    = rd_val;
                d_op2    = imm;
                src_mask = 8'b1 << f_rd;
            end
            4'h7, 4'h8: begin
                d_mode   = op;
                d_op1    = rs_val;
                d_we     = 1'b1;
                src_mask = 8'b1 << f_rs;
            end
            4'h9: begin
                d_mode   = op;
                d_op1    = rd_val;
                d_op2    = imm;
                d_we     = 1'b1;
                src_mask = 8'b1 << f_rd;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign hazard   = |(src_mask & (scoreboard | pend_mask) & ~fwd_mask);
    assign in_ready = !reset && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = IDLE;
        if (accept)
            state_next = ISSUE;
        else if (out_valid && !out_ready)
            state_next = ISSUE;
        else if (in_valid && hazard)
            state_next = STALL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            scoreboard  <= '0;
            out_mode    <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
            for (int unsigned i = 0; i < 8; i++)
                rf[i] <= '0;
        end else begin
            state      <= state_next;
            // Set wins over clear when a transfer and writeback hit the same register.
            scoreboard <= (scoreboard & ~wb_mask) | set_mask;
            if (wb_en)
                rf[wb_addr] <= wb_data;
            if (accept) begin
                out_mode    <= d_mode;
                out_op1     <= d_op1;
                out_op2     <= d_op2;
                out_rd      <= f_rd;
                out_we      <= d_we;
                out_illegal <= d_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic against a cycle model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, wb_en, out_valid, out_ready, out_we, out_illegal;
    logic [15:0] in_instr;
    logic [2:0]  wb_addr, out_rd;
    logic [7:0]  wb_data, out_op1, out_op2;
    logic [3:0]  out_mode;
    logic [24:0] obs;
    logic [21:0] obs_nr;

    int errors = 0;
    int checks = 0;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_op1(out_op1),
        .out_op2(out_op2), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    assign obs    = {out_mode, out_op1, out_op2, out_rd, out_we, out_illegal};
    assign obs_nr = {out_mode, out_op1, out_op2, out_we, out_illegal};

    // Reference model state
    logic [7:0] m_rf [8];
    logic [7:0] m_sb = '0;
    bit         m_pv = 1'b0;
    logic [3:0] m_mode = '0;
    logic [7:0] m_op1 = '0, m_op2 = '0;
    logic [2:0] m_rd = '0;
    bit         m_we = 1'b0, m_ill = 1'b0;

    bit         e_ready, e_acc, e_we, e_ill;
    logic [3:0] e_mode;
    logic [7:0] e_op1, e_op2;

    function automatic logic [15:0] ins_r(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
        return {o, d, s, t, 3'b000};
    endfunction

    function automatic logic [15:0] ins_i(input logic [3:0] o, input logic [2:0] d, input logic [7:0] im);
        return {o, d, 1'b0, im};
    endfunction

    function automatic logic [7:0] sources(input logic [15:0] ins);
        logic [7:0] s;
        s = '0;
        case (ins[15:12])
            4'h1, 4'h5, 4'h6: begin s[ins[8:6]] = 1'b1; s[ins[5:3]] = 1'b1; end
            4'h7, 4'h8:       s[ins[8:6]] = 1'b1;
            4'h3, 4'h9:       s[ins[11:9]] = 1'b1;
            default:          s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] reg_value(input int r);
        if (FWD && m_sb[r] && wb_en && (int'(wb_addr) == r))
            return wb_data;
        return m_rf[r];
    endfunction

    task automatic model_comb();
        logic [7:0] srcs;
        bit haz, pend, fwd;
        int rd, rs, rt;
        srcs = sources(in_instr);
        haz = 1'b0;
        for (int r = 0; r < 8; r++) begin
            pend = m_pv && m_we && (int'(m_rd) == r);
            fwd  = FWD && m_sb[r] && !pend && wb_en && (int'(wb_addr) == r);
            if (srcs[r] && (m_sb[r] || pend) && !fwd)
                haz = 1'b1;
        end
        e_ready = !reset && !haz && (!m_pv || out_ready);
        e_acc   = in_valid && e_ready;
        rd = int'(in_instr[11:9]);
        rs = int'(in_instr[8:6]);
        rt = int'(in_instr[5:3]);
        e_mode = in_instr[15:12];
        e_op1 = 8'h00;
        e_op2 = 8'h00;
        e_ill = 1'b0;
        e_we  = 1'b1;
        case (in_instr[15:12])
            4'h0:             e_we = 1'b0;
            4'h1, 4'h5, 4'h6: begin e_op1 = reg_value(rs); e_op2 = reg_value(rt); end
            4'h2, 4'h4:       e_op1 = in_instr[7:0];
            4'h3:             begin e_op1 = reg_value(rd); e_op2 = in_instr[7:0]; e_we = 1'b0; end
            4'h7, 4'h8:       e_op1 = reg_value(rs);
            4'h9:             begin e_op1 = reg_value(rd); e_op2 = in_instr[7:0]; end
            default:          begin e_mode = 4'h0; e_we = 1'b0; e_ill = 1'b1; end
        endcase
    endtask

    task automatic tick();
        bit xfer;
        model_comb();
        @(posedge clk);
        #1;
        if (reset) begin
            m_pv = 1'b0; m_sb = '0; m_mode = '0; m_op1 = '0; m_op2 = '0;
            m_rd = '0; m_we = 1'b0; m_ill = 1'b0;
            for (int r = 0; r < 8; r++) m_rf[r] = '0;
        end else begin
            xfer = m_pv && out_ready;
            if (wb_en) m_sb[wb_addr] = 1'b0;
            if (xfer && m_we) m_sb[m_rd] = 1'b1;
            if (wb_en) m_rf[wb_addr] = wb_data;
            if (e_acc) begin
                m_pv = 1'b1; m_mode = e_mode; m_op1 = e_op1; m_op2 = e_op2;
                m_rd = in_instr[11:9]; m_we = e_we; m_ill = e_ill;
            end else if (xfer) begin
                m_pv = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (obs !== 25'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
        checks++; if (dut.scoreboard !== 8'h00) begin errors++; $display("FAIL reset_sb: got %h want 00", dut.scoreboard); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_add();
        write_reg(3'd1, 8'h05);
        write_reg(3'd2, 8'h03);
        in_valid = 1'b1; in_instr = ins_r(4'h1, 3'd3, 3'd1, 3'd2);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
        checks++; if (obs !== {4'h1, 8'h05, 8'h03, 3'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL add_fields: got %h want %h", obs, {4'h1, 8'h05, 8'h03, 3'd3, 1'b1, 1'b0}); end
        tick();
        checks++; if (dut.scoreboard !== 8'h08) begin errors++; $display("FAIL add_sb: got %h want 08", dut.scoreboard); end
        write_reg(3'd3, 8'h08);
    endtask

    task automatic test_back_to_back();
        write_reg(3'd1, 8'h02);
        in_valid = 1'b1; in_instr = ins_i(4'h9, 3'd1, 8'hFF);
        tick();
        checks++; if (obs !== {4'h9, 8'h02, 8'hFF, 3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL addi_fields: got %h want %h", obs, {4'h9, 8'h02, 8'hFF, 3'd1, 1'b1, 1'b0}); end
        in_instr = ins_i(4'h4, 3'd5, 8'h7A);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (obs !== {4'h4, 8'h7A, 8'h00, 3'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL loadc_fields: got %h want %h", obs, {4'h4, 8'h7A, 8'h00, 3'd5, 1'b1, 1'b0}); end
        tick();
        checks++; if (dut.scoreboard !== 8'h22) begin errors++; $display("FAIL b2b_sb: got %h want 22", dut.scoreboard); end
        write_reg(3'd1, 8'h02);
        write_reg(3'd5, 8'h7A);
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; in_instr = ins_r(4'h1, 3'd4, 3'd1, 3'd2);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (dut.scoreboard !== 8'h10) begin errors++; $display("FAIL haz_sb: got %h want 10", dut.scoreboard); end
        in_valid = 1'b1; in_instr = ins_r(4'h5, 3'd6, 3'd4, 3'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_stall0: got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_stall1: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL haz_no_issue: got %b want 0", out_valid); end
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h11;
        #1;
`ifdef ALU_ISSUE_FWD_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL haz_fwd_ready: got %b want 1", in_ready); end
        tick();
        wb_en = 1'b0;
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_wb_ready: got %b want 0", in_ready); end
        tick();
        wb_en = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL haz_after_wb_ready: got %b want 1", in_ready); end
        tick();
`endif
        in_valid = 1'b0;
        checks++; if (obs !== {4'h5, 8'h11, 8'h00, 3'd6, 1'b1, 1'b0}) begin errors++; $display("FAIL haz_xor_fields: got %h want %h", obs, {4'h5, 8'h11, 8'h00, 3'd6, 1'b1, 1'b0}); end
        tick();
        checks++; if (dut.scoreboard !== 8'h40) begin errors++; $display("FAIL haz_sb_after: got %h want 40", dut.scoreboard); end
        write_reg(3'd6, 8'h00);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = ins_i(4'h4, 3'd2, 8'h33);
        tick();
        in_instr = ins_i(4'h4, 3'd7, 8'h44);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); end
            checks++; if ({out_valid, obs} !== {1'b1, 4'h4, 8'h33, 8'h00, 3'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_hold%0d: got %h want %h", i, {out_valid, obs}, {1'b1, 4'h4, 8'h33, 8'h00, 3'd2, 1'b1, 1'b0}); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, obs} !== {1'b1, 4'h4, 8'h44, 8'h00, 3'd7, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_next: got %h want %h", {out_valid, obs}, {1'b1, 4'h4, 8'h44, 8'h00, 3'd7, 1'b1, 1'b0}); end
        tick();
        checks++; if (dut.scoreboard !== 8'h84) begin errors++; $display("FAIL bp_sb: got %h want 84", dut.scoreboard); end
        write_reg(3'd2, 8'h33);
        write_reg(3'd7, 8'h44);
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_instr = 16'hC600;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, obs_nr} !== {1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1}) begin errors++; $display("FAIL illegal_fields: got %h want %h", {out_valid, obs_nr}, {1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1}); end
        tick();
        checks++; if (dut.scoreboard !== 8'h00) begin errors++; $display("FAIL illegal_sb: got %h want 00", dut.scoreboard); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_stall();
        in_valid = 1'b1; in_instr = ins_r(4'h1, 3'd4, 3'd1, 3'd2);
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_instr = ins_r(4'h5, 3'd6, 3'd4, 3'd0);
        tick();
        checks++; if ({in_ready, dut.scoreboard} !== {1'b0, 8'h10}) begin errors++; $display("FAIL rs_stalled: got %h want 010", {in_ready, dut.scoreboard}); end
        reset = 1'b1; wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h55;
        tick();
        reset = 1'b0; wb_en = 1'b0;
        #1;
        checks++; if ({out_valid, dut.scoreboard, in_ready} !== {1'b0, 8'h00, 1'b1}) begin errors++; $display("FAIL rs_after_reset: got %h want 001", {out_valid, dut.scoreboard, in_ready}); end
        tick();
        in_valid = 1'b0;
        checks++; if (obs !== {4'h5, 8'h00, 8'h00, 3'd6, 1'b1, 1'b0}) begin errors++; $display("FAIL rs_rf_cleared: got %h want %h", obs, {4'h5, 8'h00, 8'h00, 3'd6, 1'b1, 1'b0}); end
        tick();
        write_reg(3'd6, 8'h00);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_instr  = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            wb_en     = $urandom_range(0, 1) == 1;
            wb_addr   = 3'($urandom_range(0, 7));
            wb_data   = 8'($urandom);
            #1;
            model_comb();
            checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, in_ready, e_ready); end
            tick();
            checks++; if (out_valid !== m_pv) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, m_pv); end
            if (m_pv) begin
                checks++; if (obs_nr !== {m_mode, m_op1, m_op2, m_we, m_ill}) begin errors++; $display("FAIL rnd_fields[%0d]: got %h want %h", n, obs_nr, {m_mode, m_op1, m_op2, m_we, m_ill}); end
                if (m_we) begin
                    checks++; if (out_rd !== m_rd) begin errors++; $display("FAIL rnd_rd[%0d]: got %0d want %0d", n, out_rd, m_rd); end
                end
            end
            checks++; if (dut.scoreboard !== m_sb) begin errors++; $display("FAIL rnd_sb[%0d]: got %h want %h", n, dut.scoreboard, m_sb); end
        end
        reset = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    initial begin
        for (int r = 0; r < 8; r++) m_rf[r] = '0;
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_hazard();
        test_backpressure();
        test_illegal();
        test_reset_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
